// File: rtl/mmio_switch_led_port_pkg.sv
// Shared constants for the switch/LED MMIO port: bus width, default window, register offsets.
// Also holds the address decode helper used by the port.
package mmio_switch_led_port_pkg;

  localparam int          DATA_W         = 16;
  localparam logic [15:0] MMIO_BASE_ADDR = 16'hFF00;

  localparam logic [1:0] OFF_LED    = 2'd0;
  localparam logic [1:0] OFF_SWITCH = 2'd1;
  localparam logic [1:0] OFF_EDGE   = 2'd2;
  localparam logic [1:0] OFF_CFG    = 2'd3;

  typedef struct packed {
    logic       sel;
    logic [1:0] off;
    logic       wr;
  } bus_dec_t;

  // The window is four words, so the two low address bits select the register.
  function automatic bus_dec_t bus_decode(input logic [15:0] addr,
                                          input logic [15:0] base,
                                          input logic        we);
    bus_dec_t d;
    d.sel = ((addr >> 2) == (base >> 2));
    d.off = addr[1:0];
    d.wr  = d.sel && we;
    return d;
  endfunction

endpackage

// File: rtl/mmio_switch_led_port_if.sv
// CPU data-bus view seen by an MMIO responder: address/store strobe in, registered read data and hit out.
// The CPU side drives the master modport, the responder uses the slave modport.
interface mmio_switch_led_port_if
  import mmio_switch_led_port_pkg::*;
#(
  parameter int W = DATA_W
);

  logic [15:0]  bus_address;
  logic         bus_write_enable;
  logic [W-1:0] bus_write_data;
  logic [W-1:0] bus_read_data;
  logic         bus_hit;

  modport master (
    output bus_address, bus_write_enable, bus_write_data,
    input  bus_read_data, bus_hit
  );

  modport slave (
    input  bus_address, bus_write_enable, bus_write_data,
    output bus_read_data, bus_hit
  );

endinterface

// File: rtl/mmio_switch_led_port_switch_debouncer.sv
// Switch debouncer: 2-flop sync, prescaled sampling, per-bit agreement filter, rising-edge pulse.
// debounced changes only after two consecutive ticks agree; no backpressure, runs every cycle.
module mmio_switch_led_port_switch_debouncer
  import mmio_switch_led_port_pkg::*;
#(
  parameter int          WIDTH          = DATA_W,
  parameter logic [15:0] DEBOUNCE_RESET = 16'd50000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] switches_in,
  input  logic [15:0]      reload_val,
  input  logic             reload_stb,
  output logic [WIDTH-1:0] debounced,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] agree;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      reload_cnt;
  logic             tick;

  // Counting reload..0 gives a tick period of reload_val cycles; 0 is treated as 1.
  assign reload_cnt = (reload_val == 16'd0) ? 16'd0 : (reload_val - 16'd1);
  assign tick       = (cnt_q == 16'd0);
  assign agree      = ~(sync2_q ^ sample_q);

  always_comb begin
    sync1_d  = switches_in;
    sync2_d  = sync1_q;
    prev_d   = deb_q;
    sample_d = sample_q;
    deb_d    = deb_q;
    if (reload_stb || tick) begin
      cnt_d = reload_cnt;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
    if (tick) begin
      sample_d = sync2_q;
      deb_d    = (deb_q & ~agree) | (sync2_q & agree);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      sample_q <= '0;
      deb_q    <= '0;
      prev_q   <= '0;
      cnt_q    <= DEBOUNCE_RESET;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sample_q <= sample_d;
      deb_q    <= deb_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
    end
  end

  assign debounced = deb_q;
  assign rise      = deb_q & ~prev_q;

endmodule

// File: rtl/mmio_switch_led_port.sv
// MMIO LED/switch/edge-capture port, 1-cycle registered read; answers every cycle, no backpressure.
// MMIO_SWITCH_IRQ_EN turns offset 3 into IRQ_MASK, pins the debounce rate and drives a registered irq.
module mmio_switch_led_port
  import mmio_switch_led_port_pkg::*;
#(
  parameter int          WIDTH          = DATA_W,
  parameter logic [15:0] BASE_ADDR      = MMIO_BASE_ADDR,
  parameter logic [15:0] DEBOUNCE_RESET = 16'd50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      switches_in,
  mmio_switch_led_port_if.slave bus,
  output logic [WIDTH-1:0]      leds,
  output logic                  irq
);

  bus_dec_t         dec;
  logic             wr_led, wr_edge, wr_cfg;
  logic [WIDTH-1:0] led_q, led_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             hit_q, hit_d;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] cfg_rd;
  logic [WIDTH-1:0] debounced, rise;
  logic [15:0]      reload_val;
  logic             reload_stb;

  assign dec     = bus_decode(bus.bus_address, BASE_ADDR, bus.bus_write_enable);
  assign wr_led  = dec.wr && (dec.off == OFF_LED);
  assign wr_edge = dec.wr && (dec.off == OFF_EDGE);
  assign wr_cfg  = dec.wr && (dec.off == OFF_CFG);

`ifdef MMIO_SWITCH_IRQ_EN
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic             irq_q, irq_d;

  always_comb begin
    irq_mask_d = wr_cfg ? bus.bus_write_data : irq_mask_q;
    irq_d      = |(edge_q & irq_mask_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
    end
  end

  assign reload_val = DEBOUNCE_RESET;
  assign reload_stb = 1'b0;
  assign cfg_rd     = irq_mask_q;
  assign irq        = irq_q;
`else
  logic [15:0] debounce_q, debounce_d;

  always_comb begin
    debounce_d = wr_cfg ? 16'(bus.bus_write_data) : debounce_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      debounce_q <= DEBOUNCE_RESET;
    end else begin
      debounce_q <= debounce_d;
    end
  end

  // Feed the next value so a store restarts the prescaler with the new rate on the same edge.
  assign reload_val = debounce_d;
  assign reload_stb = wr_cfg;
  assign cfg_rd     = WIDTH'(debounce_q);
  assign irq        = 1'b0;
`endif

  mmio_switch_led_port_switch_debouncer #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_RESET (DEBOUNCE_RESET)
  ) u_switch_debouncer (
    .clock       (clock),
    .reset       (reset),
    .switches_in (switches_in),
    .reload_val  (reload_val),
    .reload_stb  (reload_stb),
    .debounced   (debounced),
    .rise        (rise)
  );

  // Reads use the pre-edge register values, so a same-cycle store returns the old contents.
  always_comb begin
    clr_mask = wr_edge ? bus.bus_write_data : '0;
    led_d    = wr_led ? bus.bus_write_data : led_q;
    edge_d   = (edge_q & ~clr_mask) | rise;
    hit_d    = dec.sel;
    rdata_d  = '0;
    if (dec.sel) begin
      case (dec.off)
        OFF_LED:    rdata_d = led_q;
        OFF_SWITCH: rdata_d = debounced;
        OFF_EDGE:   rdata_d = edge_q;
        default:    rdata_d = cfg_rd;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      led_q   <= '0;
      edge_q  <= '0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      led_q   <= led_d;
      edge_q  <= edge_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
    end
  end

  assign leds              = led_q;
  assign bus.bus_read_data = rdata_q;
  assign bus.bus_hit       = hit_q;

endmodule

// File: tb/tb_mmio_switch_led_port.sv
// Bench for the switch/LED MMIO port: directed scenarios plus randomized traffic against a reference model.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
module tb_mmio_switch_led_port;
  import mmio_switch_led_port_pkg::*;

  localparam logic [15:0] BASE    = 16'hFF00;
  localparam logic [15:0] DEB_RST = 16'd50000;
  localparam logic [15:0] A_LED   = {BASE[15:2], OFF_LED};
  localparam logic [15:0] A_SW    = {BASE[15:2], OFF_SWITCH};
  localparam logic [15:0] A_EDGE  = {BASE[15:2], OFF_EDGE};
  localparam logic [15:0] A_CFG   = {BASE[15:2], OFF_CFG};
`ifdef MMIO_SWITCH_IRQ_EN
  localparam logic [15:0] CFG_RST_READ = 16'h0000;
`else
  localparam logic [15:0] CFG_RST_READ = DEB_RST;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] switches_in = '0;
  logic [15:0] leds;
  logic        irq;

  mmio_switch_led_port_if #(.W(16)) bus ();

  mmio_switch_led_port #(
    .WIDTH          (16),
    .BASE_ADDR      (BASE),
    .DEBOUNCE_RESET (DEB_RST)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .switches_in (switches_in),
    .bus         (bus),
    .leds        (leds),
    .irq         (irq)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  // Reference model: register contents and the tick schedule as edge numbers.
  int unsigned k_edge, next_tick;
  logic [15:0] m_led, m_edge, m_cfg, m_mask, m_deb, m_prev, m_sample, m_rdata;
  logic        m_hit, m_irq;
  logic [15:0] sw_hist[$];
  logic        t_sel, t_wr, t_tick;
  logic [1:0]  t_off;
  logic [15:0] t_sync, t_rise, t_clr;

  function automatic int unsigned period_of(input logic [15:0] v);
    return (v == 16'd0) ? 1 : int'(v);
  endfunction

  function automatic logic [15:0] model_read(input logic [1:0] off);
    case (off)
      2'd0:    return m_led;
      2'd1:    return m_deb;
      2'd2:    return m_edge;
`ifdef MMIO_SWITCH_IRQ_EN
      default: return m_mask;
`else
      default: return m_cfg;
`endif
    endcase
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_led = '0; m_edge = '0; m_cfg = DEB_RST; m_mask = '0;
      m_deb = '0; m_prev = '0; m_sample = '0; m_rdata = '0;
      m_hit = 1'b0; m_irq = 1'b0;
      sw_hist.delete();
      k_edge = 0;
      next_tick = 32'(DEB_RST) + 1;
    end else begin
      k_edge++;
      t_sel  = ((bus.bus_address >> 2) == (BASE >> 2));
      t_off  = bus.bus_address[1:0];
      t_wr   = t_sel && bus.bus_write_enable;
      t_sync = (sw_hist.size() >= 2) ? sw_hist[sw_hist.size()-2] : 16'h0;
      sw_hist.push_back(switches_in);
      if (sw_hist.size() > 2) void'(sw_hist.pop_front());
      t_tick = (k_edge == next_tick);
      t_rise = m_deb & ~m_prev;
      t_clr  = (t_wr && t_off == 2'd2) ? bus.bus_write_data : 16'h0;
      m_rdata = t_sel ? model_read(t_off) : 16'h0;
      m_hit   = t_sel;
`ifdef MMIO_SWITCH_IRQ_EN
      m_irq = |(m_edge & m_mask);
`else
      m_irq = 1'b0;
`endif
      m_edge = (m_edge & ~t_clr) | t_rise;
      m_prev = m_deb;
      if (t_tick) begin
        for (int i = 0; i < 16; i++)
          if (t_sync[i] == m_sample[i]) m_deb[i] = t_sync[i];
        m_sample = t_sync;
      end
      if (t_wr && t_off == 2'd0) m_led = bus.bus_write_data;
`ifdef MMIO_SWITCH_IRQ_EN
      if (t_wr && t_off == 2'd3) m_mask = bus.bus_write_data;
      if (t_tick) next_tick = k_edge + period_of(DEB_RST);
`else
      if (t_wr && t_off == 2'd3) begin
        m_cfg = bus.bus_write_data;
        next_tick = k_edge + period_of(m_cfg);
      end else if (t_tick) begin
        next_tick = k_edge + period_of(m_cfg);
      end
`endif
    end
  end

  // Present one bus cycle at a falling edge and return at the next falling edge.
  task automatic bus_cycle(input logic [15:0] a, input logic we, input logic [15:0] d);
    bus.bus_address      = a;
    bus.bus_write_enable = we;
    bus.bus_write_data   = d;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (leds !== 16'h0) $display("FAIL reset_leds got=%h exp=0000", leds); else passes++;
    checks++; if (bus.bus_read_data !== 16'h0) $display("FAIL reset_rdata got=%h exp=0000", bus.bus_read_data); else passes++;
    checks++; if (bus.bus_hit !== 1'b0) $display("FAIL reset_hit got=%b exp=0", bus.bus_hit); else passes++;
    checks++; if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq); else passes++;
    reset = 1'b1;
    bus_cycle(A_CFG, 1'b0, 16'h0);
    checks++; if (bus.bus_read_data !== CFG_RST_READ) $display("FAIL reset_cfg got=%h exp=%h", bus.bus_read_data, CFG_RST_READ); else passes++;
  endtask

  task automatic test_led_rw();
    bus_cycle(A_LED, 1'b1, 16'hA5A5);
    checks++; if (leds !== 16'hA5A5) $display("FAIL led_write got=%h exp=a5a5", leds); else passes++;
    checks++; if ({bus.bus_hit, bus.bus_read_data} !== {1'b1, 16'h0000}) $display("FAIL led_read_old got=%b/%h exp=1/0000", bus.bus_hit, bus.bus_read_data); else passes++;
    bus_cycle(A_LED, 1'b0, 16'h0);
    checks++; if ({bus.bus_hit, bus.bus_read_data} !== {1'b1, 16'hA5A5}) $display("FAIL led_read got=%b/%h exp=1/a5a5", bus.bus_hit, bus.bus_read_data); else passes++;
    bus_cycle(16'h0000, 1'b0, 16'h0);
    checks++; if ({bus.bus_hit, bus.bus_read_data} !== {1'b0, 16'h0000}) $display("FAIL idle_read got=%b/%h exp=0/0000", bus.bus_hit, bus.bus_read_data); else passes++;
  endtask

  task automatic test_debounce();
    int lat = 0;
    bus_cycle(A_CFG, 1'b1, 16'd3);
    switches_in = 16'h0001;
    for (int i = 0; i < 12 && lat == 0; i++) begin
      bus_cycle(A_SW, 1'b0, 16'h0);
      checks++; if (bus.bus_read_data !== m_rdata) $display("FAIL debounce_track cyc=%0d got=%h exp=%h", i, bus.bus_read_data, m_rdata); else passes++;
      if (bus.bus_read_data === 16'h0001) lat = i + 1;
    end
    checks++; if (lat == 0 || lat > 10) $display("FAIL debounce_latency got=%0d exp=1..10", lat); else passes++;
    bus_cycle(A_EDGE, 1'b0, 16'h0);
    checks++; if (bus.bus_read_data !== 16'h0001) $display("FAIL edge_set got=%h exp=0001", bus.bus_read_data); else passes++;
    switches_in = 16'h0000;
    repeat (12) bus_cycle(16'h0000, 1'b0, 16'h0);
    bus_cycle(A_EDGE, 1'b0, 16'h0);
    checks++; if (bus.bus_read_data !== 16'h0001) $display("FAIL edge_sticky got=%h exp=0001", bus.bus_read_data); else passes++;
    bus_cycle(A_SW, 1'b0, 16'h0);
    checks++; if (bus.bus_read_data !== 16'h0000) $display("FAIL switch_fall got=%h exp=0000", bus.bus_read_data); else passes++;
  endtask

  task automatic test_glitch();
    switches_in = 16'h0002;
    repeat (2) bus_cycle(16'h0000, 1'b0, 16'h0);
    switches_in = 16'h0000;
    for (int i = 0; i < 12; i++) begin
      bus_cycle(A_SW, 1'b0, 16'h0);
      checks++; if (bus.bus_read_data !== 16'h0000) $display("FAIL glitch_switch cyc=%0d got=%h exp=0000", i, bus.bus_read_data); else passes++;
    end
    bus_cycle(A_EDGE, 1'b0, 16'h0);
    checks++; if (bus.bus_read_data !== 16'h0001) $display("FAIL glitch_edge got=%h exp=0001", bus.bus_read_data); else passes++;
  endtask

  task automatic test_w1c_set_wins();
    bit done = 0;
    switches_in = 16'h0003;
    for (int i = 0; i < 20 && m_edge != 16'h0003; i++) bus_cycle(16'h0000, 1'b0, 16'h0);
    switches_in = 16'h0002;
    for (int i = 0; i < 20 && m_deb[0]; i++) bus_cycle(16'h0000, 1'b0, 16'h0);
    switches_in = 16'h0003;
    for (int i = 0; i < 20 && !done; i++) begin
      if (m_deb[0] && !m_prev[0]) begin
        bus_cycle(A_EDGE, 1'b1, 16'h0001);
        done = 1;
      end else begin
        bus_cycle(16'h0000, 1'b0, 16'h0);
      end
    end
    checks++; if (!done) $display("FAIL w1c_rise_timeout got=none exp=rise on bit0"); else passes++;
    bus_cycle(A_EDGE, 1'b0, 16'h0);
    checks++; if (bus.bus_read_data !== 16'h0003) $display("FAIL w1c_set_wins got=%h exp=0003", bus.bus_read_data); else passes++;
    bus_cycle(A_EDGE, 1'b1, 16'h0003);
    bus_cycle(A_EDGE, 1'b0, 16'h0);
    checks++; if (bus.bus_read_data !== 16'h0000) $display("FAIL w1c_clear got=%h exp=0000", bus.bus_read_data); else passes++;
  endtask

  task automatic test_outside_window();
    bus_cycle(16'hFE00, 1'b0, 16'h0);
    checks++; if ({bus.bus_hit, bus.bus_read_data} !== {1'b0, 16'h0000}) $display("FAIL miss_fe00 got=%b/%h exp=0/0000", bus.bus_hit, bus.bus_read_data); else passes++;
    bus_cycle(16'hFF04, 1'b0, 16'h0);
    checks++; if (bus.bus_hit !== 1'b0) $display("FAIL miss_ff04 got=%b exp=0", bus.bus_hit); else passes++;
    bus_cycle(16'hFEFF, 1'b1, 16'hFFFF);
    checks++; if (leds !== 16'hA5A5) $display("FAIL miss_write_led got=%h exp=a5a5", leds); else passes++;
    bus_cycle(A_SW, 1'b1, 16'h1234);
    bus_cycle(A_SW, 1'b0, 16'h0);
    checks++; if (bus.bus_read_data !== 16'h0003) $display("FAIL switch_ro got=%h exp=0003", bus.bus_read_data); else passes++;
  endtask

  task automatic test_random();
    logic [15:0] a, d;
    logic        we;
    int          pick, bitn;
    for (int i = 0; i < 600; i++) begin
      pick = $urandom_range(0, 5);
      if (pick < 4)       a = {BASE[15:2], 2'(pick)};
      else if (pick == 4) a = 16'($urandom);
      else                a = ($urandom_range(0, 1) == 0) ? 16'hFF04 : 16'hFEFF;
      we = ($urandom_range(0, 3) == 0);
      d  = 16'($urandom);
      if ((a >> 2) == (BASE >> 2) && a[1:0] == OFF_CFG) d = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) begin
        bitn = $urandom_range(0, 3);
        switches_in[bitn] = ~switches_in[bitn];
      end
      bus_cycle(a, we, d);
      checks++;
      if ({leds, bus.bus_read_data, bus.bus_hit, irq} !== {m_led, m_rdata, m_hit, m_irq})
        $display("FAIL random cyc=%0d got=%h/%h/%b/%b exp=%h/%h/%b/%b", i, leds, bus.bus_read_data, bus.bus_hit, irq, m_led, m_rdata, m_hit, m_irq);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    bus_cycle(A_LED, 1'b1, 16'h5A5A);
    checks++; if (leds !== 16'h5A5A) $display("FAIL pre_reset_led got=%h exp=5a5a", leds); else passes++;
    bus.bus_address = A_LED; bus.bus_write_enable = 1'b0;
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    checks++; if ({leds, bus.bus_read_data, bus.bus_hit} !== {16'h0, 16'h0, 1'b0}) $display("FAIL mid_reset got=%h/%h/%b exp=0000/0000/0", leds, bus.bus_read_data, bus.bus_hit); else passes++;
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    bus_cycle(A_EDGE, 1'b0, 16'h0);
    checks++; if (bus.bus_read_data !== 16'h0000) $display("FAIL reset_edge got=%h exp=0000", bus.bus_read_data); else passes++;
    bus_cycle(A_CFG, 1'b0, 16'h0);
    checks++; if (bus.bus_read_data !== CFG_RST_READ) $display("FAIL reset_cfg_mid got=%h exp=%h", bus.bus_read_data, CFG_RST_READ); else passes++;
  endtask

  initial begin
    bus.bus_address      = '0;
    bus.bus_write_enable = 1'b0;
    bus.bus_write_data   = '0;
    @(negedge clock);
    test_reset();
    test_led_rw();
    test_debounce();
    test_glitch();
    test_w1c_set_wins();
    test_outside_window();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
